// File: rtl/ysyx_25020047_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020047_lsu_mc
// Brief    : Multi-cycle load/store unit. Takes one EXU op per handshake, runs
//            a valid/ready data-bus transaction with byte strobes, and returns
//            extended load data or a fault code.
// Revision : 1.0
// ============================================================================
module ysyx_25020047_lsu_mc #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wen,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic                mem_wen,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_resp_err,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic [1:0]          out_fault
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] FLT_NONE     = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_BUS      = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                wen_q, wen_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [1:0]          fault_q, fault_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;

    logic [OFF_W-1:0]    in_off;
    logic                misaligned;
    logic [STRB_W-1:0]   strb_base;
    logic [STRB_W-1:0]   strb_lane;
    logic [XLEN-1:0]     wdata_shift;
    logic [XLEN-1:0]     wdata_lane;

    // Request-side decode straight from the EXU fields, latched on accept.
    always_comb begin
        in_off      = in_addr[OFF_W-1:0];
        strb_base   = '0;
        wdata_lane  = '0;
        case (in_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = |in_addr[1:0];
            default: misaligned = (XLEN == 32) ? 1'b1 : |in_addr[2:0];
        endcase
        for (int i = 0; i < STRB_W; i++) begin
            strb_base[i] = (i < (1 << in_size));
        end
        strb_lane   = strb_base << in_off;
        wdata_shift = in_wdata << {in_off, 3'b000};
        // Lanes outside the strobe are driven to zero rather than left as shifted junk.
        for (int i = 0; i < STRB_W; i++) begin
            wdata_lane[8*i +: 8] = strb_lane[i] ? wdata_shift[8*i +: 8] : 8'h00;
        end
    end

    logic [XLEN-1:0]     ld_field;
    logic [XLEN-1:0]     ld_mask;
    logic [XLEN-1:0]     ld_ext;
    logic                ld_msb;

    always_comb begin
        ld_field = mem_rdata >> {off_q, 3'b000};
        ld_mask  = '0;
        ld_msb   = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            ld_mask[i] = (i < (8 << size_q));
            if (i == (8 << size_q) - 1) begin
                ld_msb = ld_field[i];
            end
        end
        ld_ext = ld_field & ld_mask;
        // A full-width field has an all-ones mask, so extension is a no-op there.
        if (!unsigned_q && ld_msb) begin
            ld_ext = ld_ext | ~ld_mask;
        end
    end

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    wen_d      = in_wen;
                    size_d     = in_size;
                    unsigned_d = in_unsigned;
                    off_d      = in_off;
                    addr_d     = {in_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_d    = in_wen ? wdata_lane : '0;
                    wstrb_d    = in_wen ? strb_lane : '0;
                    rdata_d    = '0;
                    if (misaligned) begin
                        fault_d = FLT_MISALIGN;
                        state_d = S_DONE;
                    end else begin
                        fault_d = FLT_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_DONE;
                    if (mem_resp_err) begin
                        fault_d = FLT_BUS;
                        rdata_d = '0;
                    end else begin
                        fault_d = FLT_NONE;
                        rdata_d = wen_q ? '0 : ld_ext;
                    end
                end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
                    fault_d = FLT_TIMEOUT;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wen_q      <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= FLT_NONE;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            wen_q      <= wen_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
            wdog_q     <= wdog_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign out_valid     = (state_q == S_DONE);
    assign out_rdata     = rdata_q;
    assign out_fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020047_lsu_mc
// Brief    : Scoreboard bench driving a 32-bit and a 64-bit LSU instance in turn
//            against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_ysyx_25020047_lsu_mc;

    localparam int TO = 4;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          rdy_dly;
        int          resp_dly;
    } bus_t;

    typedef struct {
        logic [1:0]  fault;
        logic [63:0] rdata;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0, in_wen = 1'b0, in_unsigned = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic [63:0] in_addr = '0, in_wdata = '0;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_req_valid, a_wen, a_out_valid;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic [1:0]  a_fault;
    logic        b_in_valid, b_in_ready, b_req_valid, b_wen, b_out_valid;
    logic [63:0] b_addr, b_wdata, b_rdata;
    logic [7:0]  b_wstrb;
    logic [1:0]  b_fault;

    assign a_in_valid = in_valid & sel;
    assign b_in_valid = in_valid & ~sel;

    ysyx_25020047_lsu_mc #(.XLEN(32), .TIMEOUT(TO), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_wen(in_wen), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr[31:0]), .in_wdata(in_wdata[31:0]),
        .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_addr),
        .mem_wen(a_wen), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata[31:0]), .mem_resp_err(mem_resp_err),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_rdata(a_rdata), .out_fault(a_fault)
    );

    ysyx_25020047_lsu_mc #(.XLEN(64), .TIMEOUT(TO), .CNT_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_wen(in_wen), .in_size(in_size),
        .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_addr),
        .mem_wen(b_wen), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_rdata(b_rdata), .out_fault(b_fault)
    );

    logic        o_in_ready, o_req_valid, o_wen, o_out_valid;
    logic [63:0] o_addr, o_wdata, o_rdata;
    logic [7:0]  o_wstrb;
    logic [1:0]  o_fault;

    always_comb begin
        o_in_ready  = sel ? a_in_ready  : b_in_ready;
        o_req_valid = sel ? a_req_valid : b_req_valid;
        o_wen       = sel ? a_wen       : b_wen;
        o_out_valid = sel ? a_out_valid : b_out_valid;
        o_addr      = sel ? {32'h0, a_addr}  : b_addr;
        o_wdata     = sel ? {32'h0, a_wdata} : b_wdata;
        o_rdata     = sel ? {32'h0, a_rdata} : b_rdata;
        o_wstrb     = sel ? {4'h0, a_wstrb}  : b_wstrb;
        o_fault     = sel ? a_fault : b_fault;
    end

    bus_t bus_q[$];
    out_t out_q[$];
    int   checks = 0;
    int   failures = 0;
    int   hold_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte-level arithmetic on the architectural rules.
    function automatic void model(input int xlen, input logic wen, input logic [1:0] size,
                                  input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                                  input logic [63:0] rdata, input logic err, input int dly,
                                  output logic mis, output bus_t b, output out_t o);
        int          nb;
        int          wb;
        int          off;
        logic [63:0] xmask;
        logic [63:0] fmask;
        logic [63:0] field;
        logic [63:0] sh;
        nb    = 1 << size;
        wb    = xlen / 8;
        off   = int'(addr % 64'(wb));
        xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mis   = (xlen == 32 && size == 2'd3) || (addr % 64'(nb) != 0);
        b.addr     = addr - 64'(off);
        b.wen      = wen;
        b.strb     = wen ? 8'(((1 << nb) - 1) << off) : 8'h00;
        sh         = (wdata << (8 * off)) & xmask;
        for (int k = 0; k < 8; k++) if (!b.strb[k]) sh[8*k +: 8] = 8'h00;
        b.wdata    = sh;
        b.rdata    = rdata & xmask;
        b.err      = err;
        b.rdy_dly  = 0;
        b.resp_dly = dly;
        o.rdata = 64'h0;
        if (mis)              o.fault = 2'd1;
        else if (dly >= TO)   o.fault = 2'd3;
        else if (err)         o.fault = 2'd2;
        else begin
            o.fault = 2'd0;
            if (!wen) begin
                fmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
                field = (b.rdata >> (8 * off)) & fmask;
                if (!uns && nb < 8 && field[8*nb-1]) field = field | ~fmask;
                o.rdata = field & xmask;
            end
        end
    endfunction

    // Bus responder: checks each request against the expected queue.
    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (rst_n && o_req_valid) begin
                if (bus_q.size() == 0) begin
                    chk("req_without_op", {63'h0, o_req_valid}, 64'h0);
                end else begin
                    b = bus_q.pop_front();
                    for (int k = 0; k <= b.rdy_dly; k++) begin
                        if (k > 0) @(negedge clk);
                        chk("req_valid", {63'h0, o_req_valid}, 64'h1);
                        chk("mem_addr", o_addr, b.addr);
                        chk("mem_wen", {63'h0, o_wen}, {63'h0, b.wen});
                        chk("mem_wstrb", {56'h0, o_wstrb}, {56'h0, b.strb});
                        if (b.wen) chk("mem_wdata", o_wdata, b.wdata);
                    end
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    repeat (b.resp_dly) @(negedge clk);
                    mem_resp_valid = 1'b1;
                    mem_resp_err   = b.err;
                    mem_rdata      = b.rdata;
                    @(negedge clk);
                    mem_resp_valid = 1'b0;
                    mem_resp_err   = 1'b0;
                    mem_rdata      = {$urandom, $urandom};
                end
            end
        end
    end

    // Output monitor: compares the held result every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_out_valid) begin
                if (out_q.size() == 0) begin
                    chk("out_without_op", {63'h0, o_out_valid}, 64'h0);
                end else begin
                    chk("out_fault", {62'h0, o_fault}, {62'h0, out_q[0].fault});
                    chk("out_rdata", o_rdata, out_q[0].rdata);
                    chk("in_ready_busy", {63'h0, o_in_ready}, 64'h0);
                end
                if (hold_cyc > 0) begin
                    hold_cyc--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = ($urandom % 4) != 0;
                end
                if (out_ready && out_q.size() > 0) void'(out_q.pop_front());
            end else begin
                out_ready = 1'($urandom % 2);
            end
        end
    end

    task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic err, input int rdy, input int dly, input int meas,
                         input bit exp_out);
        int          xlen;
        int          n;
        logic        mis;
        bus_t        b;
        out_t        o;
        logic [63:0] xmask;
        xlen  = sel ? 32 : 64;
        xmask = sel ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        n = 0;
        while (!o_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("in_ready_wait", {63'h0, o_in_ready}, 64'h1);
        model(xlen, wen, size, uns, addr & xmask, wdata & xmask, rdata, err, dly, mis, b, o);
        b.rdy_dly = rdy;
        if (!mis) bus_q.push_back(b);
        if (exp_out) out_q.push_back(o);
        in_valid    = 1'b1;
        in_wen      = wen;
        in_size     = size;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wdata;
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};
        if (meas > 0) begin
            n = 1;
            while (!o_out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("latency", 64'(n), 64'(meas));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_q.size() != 0 || !o_in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain", 64'(out_q.size()), 64'h0);
        repeat (10) @(negedge clk);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"}, {63'h0, o_in_ready}, 64'h1);
        chk({tag, "_req_valid"}, {63'h0, o_req_valid}, 64'h0);
        chk({tag, "_out_valid"}, {63'h0, o_out_valid}, 64'h0);
        chk({tag, "_fault"}, {62'h0, o_fault}, 64'h0);
        chk({tag, "_rdata"}, o_rdata, 64'h0);
        chk({tag, "_addr"}, o_addr, 64'h0);
        chk({tag, "_wdata"}, o_wdata, 64'h0);
        chk({tag, "_wstrb"}, {56'h0, o_wstrb}, 64'h0);
        chk({tag, "_wen"}, {63'h0, o_wen}, 64'h0);
    endtask

    task automatic random_ops(input int count);
        logic [1:0]  size;
        logic [63:0] addr;
        int          dly;
        for (int i = 0; i < count; i++) begin
            size = 2'($urandom % 4);
            addr = {32'($urandom), 32'h8000_0000 + 32'($urandom_range(0, 255))};
            if (($urandom % 3) != 0) addr = addr & ~(64'((1 << size) - 1));
            dly = (($urandom % 5) == 0) ? TO + int'($urandom % 2) : int'($urandom % TO);
            issue(1'($urandom % 2), size, 1'($urandom % 2), addr, {$urandom, $urandom},
                  {$urandom, $urandom}, ($urandom % 8) == 0, int'($urandom % 3), dly, 0, 1'b1);
        end
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        sel = 1'b1; #1 reset_vals("rst32");
        sel = 1'b0; #1 reset_vals("rst64");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b1;
        // lb at byte 3 sign-extends 0x80
        issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h80FF_FF12, 1'b0, 0, 0, 3, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 64'h8000_0002, 64'h1234_ABCD, 64'h0, 1'b0, 0, 0, 3, 1'b1);
        hold_cyc = 5;
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0006, 64'h0, 64'h0, 1'b0, 0, 0, 1, 1'b1);
        drain();
        issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0, 64'h0, 1'b0, 0, 0, 1, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 64'h8000_0002, 64'h0, 64'h9876_5432, 1'b1, 0, 0, 3, 1'b1);
        drain();
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'h1111_2222, 1'b0, 0, 5, 2 + TO, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'hCAFE_F00D, 1'b0, 0, TO - 1, 0, 1'b1);
        drain();

        // Abort an op in WAIT; its late response must be dropped.
        issue(1'b0, 2'd2, 1'b0, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF, 1'b0, 0, 6, 0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_in_ready", {63'h0, o_in_ready}, 64'h1);
        issue(1'b0, 2'd0, 1'b1, 64'h8000_0001, 64'h0, 64'h0000_8100, 1'b0, 0, 0, 3, 1'b1);
        random_ops(60);
        drain();

        sel = 1'b0;
        @(negedge clk);
        issue(1'b0, 2'd2, 1'b1, 64'h0000_0000_8000_0004, 64'h0, 64'hF000_0001_0000_0000, 1'b0, 0, 0, 3, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 64'hF000_0001_0000_0000, 1'b0, 0, 0, 3, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 0, 0, 3, 1'b1);
        issue(1'b0, 2'd3, 1'b1, 64'h0000_0000_8000_0010, 64'h0, 64'h8000_0000_0000_0001, 1'b0, 1, 1, 0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 64'h0000_0000_8000_0014, 64'h0, 64'h0, 1'b0, 0, 0, 1, 1'b1);
        drain();
        random_ops(60);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25020047_lsu_mc.md
Name: ysyx_25020047_lsu_mc

Overview:
- Multi-cycle load/store unit between EXU and the data-memory bus; successor to the single-cycle combinational DPI LSU.
- Accepts one memory op per handshake, drives a valid/ready bus with byte strobes, and returns sign/zero-extended load data or a fault.
- Generalised in XLEN (32/64, adds ld/lwu/sd at 64), adds misalignment detection and a bus timeout watchdog.

Parameters:
- XLEN, 32, data/address width; 32 or 64 only.
- TIMEOUT, 255, WAIT-state cycles before timeout fault; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EXU op valid.
- in_ready  out  1  LSU can accept an op; high only in IDLE.
- in_wen  in  1  1=store, 0=load.
- in_size  in  2  0=byte, 1=half, 2=word, 3=double (legal only when XLEN=64).
- in_unsigned  in  1  zero-extend load result (lbu/lhu/lwu).
- in_addr  in  XLEN  byte address.
- in_wdata  in  XLEN  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  XLEN  address aligned down to XLEN/8 bytes.
- mem_wen  out  1  write request.
- mem_wdata  out  XLEN  store data shifted to byte lane.
- mem_wstrb  out  XLEN/8  byte strobes.
- mem_resp_valid  in  1  bus response valid (always accepted).
- mem_rdata  in  XLEN  read data, full aligned word.
- mem_resp_err  in  1  bus error.
- out_valid  out  1  result valid.
- out_ready  in  1  WBU consumes result.
- out_rdata  out  XLEN  extended load data; 0 for stores and faults.
- out_fault  out  2  0=none, 1=misaligned, 2=bus error, 3=timeout.

Behaviour:
- Reset: state=IDLE, in_ready=1, mem_req_valid=0, out_valid=0, out_fault=0, out_rdata=0, mem_addr/mem_wdata/mem_wstrb/mem_wen=0, watchdog=0. Reset asserted mid-op aborts immediately; any later bus response is discarded because the state is IDLE.
- States IDLE, REQ, WAIT, DONE.
- IDLE: on in_valid, latch all in_* fields.
  - Misaligned (addr mod 2^size != 0), or size=3 with XLEN=32: go to DONE with fault=1; no bus access.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, and all mem_* outputs stay stable until the handshake. On mem_req_ready go to WAIT and clear the watchdog.
- WAIT: the watchdog increments each cycle.
  - On mem_resp_valid, capture the response and go to DONE; fault=2 if mem_resp_err.
  - Else, when TIMEOUT!=0 and watchdog==TIMEOUT-1, go to DONE with fault=3.
  - A response arriving in the same cycle as the timeout wins.
- DONE: out_valid=1 and outputs are held until out_ready, then return to IDLE. in_ready goes high the cycle after the out handshake (no IDLE bypass).
- Latency: with zero-wait bus (ready in REQ, response the cycle after), a load accepted at cycle 0 gives REQ@1, WAIT@2 (resp), out_valid@3. A misaligned op gives out_valid@1.
- Store lanes, with off = addr[log2(XLEN/8)-1:0]:
  - wstrb = ((1<<(1<<size))-1) << off.
  - wdata = in_wdata << (8*off); bytes outside the strobe are don't-care, driven 0.
  - Load requests drive wstrb=0.
- Load extract: field = mem_rdata >> (8*off), truncated to 8/16/32/64 bits. Sign-extend from the field MSB unless in_unsigned; size=3 ignores in_unsigned.
- Store completion returns out_rdata=0, fault=0 (or 2/3).
- mem_resp_valid outside WAIT is ignored.
- in_valid while in_ready=0 is ignored; EXU must hold it.

Test Plan:
- XLEN=32 lb at 0x8000_0003, mem_rdata=0x80FF_FF12 -> wstrb=0, mem_addr=0x8000_0000, out_rdata=0xFFFF_FF80, fault=0, out_valid 3 cycles after accept.
- XLEN=32 sh at 0x8000_0002, wdata=0x1234_ABCD -> mem_wstrb=0xC, mem_wdata=0xABCD_0000, then out_rdata=0, fault=0.
- lw at 0x8000_0006 -> no mem_req_valid ever, out_valid next cycle, fault=1; out_ready held low 5 cycles -> outputs stable and in_ready=0 throughout.
- TIMEOUT=4, bus accepts but never responds -> fault=3 exactly 4 cycles after entering WAIT; a response injected afterwards is ignored and the next op completes normally.
- XLEN=64 lwu at 0x...04, rdata=0xF000_0001_0000_0000 -> out_rdata=0x0000_0000_F000_0001. Same data with lw -> 0xFFFF_FFFF_F000_0001. sd at 0x...08 -> wstrb=0xFF.
- rst_n pulsed low while in WAIT -> all outputs return to reset values asynchronously; a response arriving after release is discarded and in_ready=1.
